// File: rtl/wb_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_arb_pkg
//  Purpose  : Shared definitions for the dp_ram Wishbone arbiter: FSM state
//             encoding and the round-robin next-grant search.
//  Revision : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

  // Largest master count the round-robin search is sized for
  localparam int MAX_MASTERS = 8;

  // Arbiter FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  // Round-robin pick: index of the first requester found searching upward from
  // last+1 (wrapping at n), or -1 when the request vector is empty.
  function automatic int rr_next_grant(input logic [MAX_MASTERS-1:0] req,
                                       input int last,
                                       input int n);
    int         pick;
    logic [2:0] cand;
    pick = -1;
    for (int k = 1; k <= MAX_MASTERS; k++) begin
      cand = 3'((last + k) % n);
      if ((k <= n) && (pick < 0) && req[cand]) begin
        pick = int'(cand);
      end
    end
    return pick;
  endfunction

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ram_arbiter_if
//  Purpose  : Bundle of the per-master Wishbone request side and the shared
//             dp_ram slave side handled by the arbiter.
//             slave  : view of the arbiter itself
//             master : view of the environment (masters plus the RAM)
//  Revision : 1.0  initial release
// ============================================================================
interface wb_ram_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8
);
  // Master side, flattened with master i at [i*WIDTH +: WIDTH]
  logic [NUM_MASTERS-1:0]            m_cyc_in;
  logic [NUM_MASTERS-1:0]            m_stb_in;
  logic [NUM_MASTERS-1:0]            m_we_in;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_in;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_in;
  logic [NUM_MASTERS-1:0]            m_ack_o;
  logic [DATA_WIDTH-1:0]             m_dat_o;
  // dp_ram slave side
  logic                              s_cyc_o;
  logic                              s_stb_o;
  logic                              s_we_o;
  logic [ADDR_WIDTH-1:0]             s_adr_o;
  logic [DATA_WIDTH-1:0]             s_dat_o;
  logic                              s_ack_in;
  logic [DATA_WIDTH-1:0]             s_dat_in;
  // Status
  logic [NUM_MASTERS-1:0]            grant_o;

  modport slave (
    input  m_cyc_in, m_stb_in, m_we_in, m_adr_in, m_dat_in, s_ack_in, s_dat_in,
    output m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, grant_o
  );

  modport master (
    output m_cyc_in, m_stb_in, m_we_in, m_adr_in, m_dat_in, s_ack_in, s_dat_in,
    input  m_ack_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, grant_o
  );
endinterface : wb_ram_arbiter_if
`default_nettype wire

// File: rtl/wb_ram_arbiter_rr_priority_sel.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_sel
//  Purpose  : Combinational round-robin selector. Given a request vector and
//             the index of the last winner, returns the next winner as both a
//             one-hot vector and a binary index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_priority_sel
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   any_o
);

  int w_pick;

  // Search upward from ptr_i+1 and expand the winning index to one-hot
  always_comb begin
    w_pick = rr_next_grant(MAX_MASTERS'(req_i), int'(ptr_i), NUM_MASTERS);
    any_o  = (w_pick >= 0);
    idx_o  = any_o ? IDX_W'(w_pick) : '0;
    gnt_o  = any_o ? (NUM_MASTERS'(1) << idx_o) : '0;
  end

endmodule : rr_priority_sel
`default_nettype wire

// File: rtl/wb_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_ram_arbiter
//  Purpose  : Round-robin arbiter sharing the dp_ram Wishbone slave port among
//             NUM_MASTERS classic Wishbone masters. A grant is held for the
//             owner's whole cyc period; ack is routed only to the owner.
//  Revision : 1.0  initial release
// ============================================================================
module wb_ram_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8
) (
  input  logic            wb_clk_in,
  input  logic            wb_rst_in,
  wb_ram_arbiter_if.slave bus
);

  localparam int               C_IDX_W    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // Pointer starts on the last master so master 0 wins the first contention
  localparam logic [C_IDX_W-1:0] C_LAST_RST = C_IDX_W'(NUM_MASTERS - 1);

  logic [0:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [C_IDX_W-1:0]     last_q,  last_d;

  logic [NUM_MASTERS-1:0] w_sel_gnt;
  logic [C_IDX_W-1:0]     w_sel_idx;
  logic                   w_sel_any;
  logic                   w_owner_cyc;

  rr_priority_sel #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (C_IDX_W)
  ) u_sel (
    .req_i (bus.m_cyc_in),
    .ptr_i (last_q),
    .gnt_o (w_sel_gnt),
    .idx_o (w_sel_idx),
    .any_o (w_sel_any)
  );

  assign w_owner_cyc = |(grant_q & bus.m_cyc_in);

  // Next grant: hold while the owner keeps cyc, otherwise hand over at the same
  // edge (the owner's cyc is low, so the search naturally starts after it)
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (w_sel_any) begin
          state_d = ST_OWNED;
          grant_d = w_sel_gnt;
          last_d  = w_sel_idx;
        end
      end
      ST_OWNED: begin
        if (!w_owner_cyc) begin
          if (w_sel_any) begin
            grant_d = w_sel_gnt;
            last_d  = w_sel_idx;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge wb_clk_in) begin
    if (wb_rst_in) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= C_LAST_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Slave mux driven by the registered grant; all-zero when nobody owns the bus
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        bus.s_cyc_o = bus.m_cyc_in[i];
        bus.s_stb_o = bus.m_stb_in[i];
        bus.s_we_o  = bus.m_we_in[i];
        bus.s_adr_o = bus.m_adr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.s_dat_o = bus.m_dat_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ack only to the current owner while its cyc is still high; read data is
  // broadcast and qualified by each master's own ack
  assign bus.m_ack_o = {NUM_MASTERS{bus.s_ack_in}} & grant_q & bus.m_cyc_in;
  assign bus.m_dat_o = bus.s_dat_in;
  assign bus.grant_o = grant_q;

endmodule : wb_ram_arbiter
`default_nettype wire
